// File: rtl/spec_integrator.sv
// Per-channel time integrator: accumulates NUM_INT consecutive spectra of
// NUM_CHAN channels in a block RAM through a 3-stage read-modify-write pipe
// and emits one integrated spectrum per NUM_INT input spectra.
module spec_integrator #(
  parameter  int DATA_WIDTH = 16,
  parameter  int ACC_WIDTH  = 32,
  parameter  int NUM_CHAN   = 1024,
  parameter  int NUM_INT    = 16,
  localparam int CHAN_WIDTH = $clog2(NUM_CHAN),
  localparam int INT_WIDTH  = $clog2(NUM_INT)
) (
  input  logic                  clk_data,
  input  logic                  rst,
  input  logic                  data_in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_sync,
  output logic [ACC_WIDTH-1:0]  data_out,
  output logic [CHAN_WIDTH-1:0] data_out_chan,
  output logic                  data_out_valid,
  output logic                  data_out_last,
  output logic                  sync_err,
  output logic                  sat_flag
);

  localparam logic [CHAN_WIDTH-1:0] LAST_CHAN = CHAN_WIDTH'(NUM_CHAN - 1);
  localparam logic [INT_WIDTH-1:0]  LAST_INT  = INT_WIDTH'(NUM_INT - 1);
  localparam int                    PAD_W     = ACC_WIDTH + 1 - DATA_WIDTH;

  // One beat as it travels from S0 into S1
  typedef struct packed {
    logic [CHAN_WIDTH-1:0] chan;
    logic [INT_WIDTH-1:0]  frame;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  logic [CHAN_WIDTH-1:0] r_chan;
  logic [INT_WIDTH-1:0]  r_frame;
  logic                  w_misalign;
  logic [CHAN_WIDTH-1:0] w_chan;
  logic [INT_WIDTH-1:0]  w_frame;

  logic                  r_s1_vld;
  beat_t                 r_s1;
  logic [ACC_WIDTH-1:0]  r_rd;
  logic [ACC_WIDTH-1:0]  r_mem [NUM_CHAN];

  logic [ACC_WIDTH-1:0]  w_base;
  logic [ACC_WIDTH:0]    w_sum_wide;
  logic                  w_ovf;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_emit;
  logic                  w_wr;

  // S0: a sync off channel 0 restarts the integration at chan 0, frame 0
  always_comb begin
    w_misalign = data_in_sync && (r_chan != '0);
    w_chan     = w_misalign ? '0 : r_chan;
    w_frame    = w_misalign ? '0 : r_frame;
  end

  // Channel / frame counters advance once per valid beat
  always_ff @(posedge clk_data) begin
    if (rst) begin
      r_chan  <= '0;
      r_frame <= '0;
    end else if (data_in_valid) begin
      if (w_chan == LAST_CHAN) begin
        r_chan  <= '0;
        r_frame <= (w_frame == LAST_INT) ? '0 : w_frame + 1'b1;
      end else begin
        r_chan  <= w_chan + 1'b1;
        r_frame <= w_frame;
      end
    end
  end

  // S0 -> S1 beat register and misaligned-sync pulse
  always_ff @(posedge clk_data) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
      sync_err <= 1'b0;
    end else begin
      r_s1_vld <= data_in_valid;
      sync_err <= data_in_valid && w_misalign;
      if (data_in_valid) r_s1 <= '{chan: w_chan, frame: w_frame, data: data_in};
    end
  end

  // S1: accumulate with saturation; frame 0 discards stale RAM contents
  always_comb begin
    w_base     = (r_s1.frame == '0) ? '0 : r_rd;
    w_sum_wide = {1'b0, w_base} + {{PAD_W{1'b0}}, r_s1.data};
    w_ovf      = w_sum_wide[ACC_WIDTH];
    w_sum      = w_ovf ? '1 : w_sum_wide[ACC_WIDTH-1:0];
    w_emit     = r_s1_vld && (r_s1.frame == LAST_INT);
    w_wr       = r_s1_vld && (r_s1.frame != LAST_INT) && !rst;
  end

  // Accumulator RAM: read in S0, write-back in S2 (no reset, contents are don't-care)
  always_ff @(posedge clk_data) begin
    r_rd <= r_mem[w_chan];
    if (w_wr) r_mem[r_s1.chan] <= w_sum;
  end

  // S2: emit the final frame's sums; data/chan hold between valid beats
  always_ff @(posedge clk_data) begin
    if (rst) begin
      data_out       <= '0;
      data_out_chan  <= '0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
      sat_flag       <= 1'b0;
    end else begin
      data_out_valid <= w_emit;
      data_out_last  <= w_emit && (r_s1.chan == LAST_CHAN);
      if (w_emit) begin
        data_out      <= w_sum;
        data_out_chan <= r_s1.chan;
      end
      if (r_s1_vld && w_ovf) sat_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spec_integrator.sv
// Directed table-driven bench for spec_integrator (4 channels, 2 spectra),
// with a 16-bit accumulator copy sharing the stimulus for saturation.
module tb_spec_integrator;

  logic        clk_data = 1'b0;
  logic        rst = 1'b1;
  logic        v = 1'b0;
  logic        s = 1'b0;
  logic [15:0] d = '0;

  logic [31:0] o_d;
  logic [1:0]  o_ch;
  logic        o_v, o_l, o_se, o_sat;
  logic [15:0] q_d;
  logic [1:0]  q_ch;
  logic        q_v, q_l, q_se, q_sat;

  spec_integrator #(.DATA_WIDTH(16), .ACC_WIDTH(32), .NUM_CHAN(4), .NUM_INT(2)) u_dut (
    .clk_data(clk_data), .rst(rst), .data_in_valid(v), .data_in(d), .data_in_sync(s),
    .data_out(o_d), .data_out_chan(o_ch), .data_out_valid(o_v), .data_out_last(o_l),
    .sync_err(o_se), .sat_flag(o_sat));

  spec_integrator #(.DATA_WIDTH(16), .ACC_WIDTH(16), .NUM_CHAN(4), .NUM_INT(2)) u_sat (
    .clk_data(clk_data), .rst(rst), .data_in_valid(v), .data_in(d), .data_in_sync(s),
    .data_out(q_d), .data_out_chan(q_ch), .data_out_valid(q_v), .data_out_last(q_l),
    .sync_err(q_se), .sat_flag(q_sat));

  always #5 clk_data = ~clk_data;

  typedef struct {
    logic        v;
    logic        s;
    logic [15:0] d;
    logic        ov;
    logic [31:0] ed;
    logic [1:0]  ech;
    logic        el;
    logic        serr;
  } row_t;

  row_t tq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic vv, input logic ss, input logic [15:0] dd);
    row_t r;
    r = '{vv, ss, dd, 1'b0, 32'd0, 2'd0, 1'b0, 1'b0};
    tq.push_back(r);
  endtask

  task automatic expo(input int idx, input logic [31:0] ed, input logic [1:0] ch, input logic l);
    row_t r;
    r = tq[idx];
    r.ov = 1'b1; r.ed = ed; r.ech = ch; r.el = l;
    tq[idx] = r;
  endtask

  task automatic exp_serr(input int idx);
    row_t r;
    r = tq[idx];
    r.serr = 1'b1;
    tq[idx] = r;
  endtask

  // Apply rows [a,b): inputs just after posedge, outputs compared on negedge
  task automatic run(input int a, input int b);
    for (int i = a; i < b; i++) begin
      v = tq[i].v; s = tq[i].s; d = tq[i].d;
      @(negedge clk_data);
      chk($sformatf("row%0d valid", i), 64'(o_v), 64'(tq[i].ov));
      chk($sformatf("row%0d sync_err", i), 64'(o_se), 64'(tq[i].serr));
      if (tq[i].ov) begin
        chk($sformatf("row%0d data", i), 64'(o_d), 64'(tq[i].ed));
        chk($sformatf("row%0d chan", i), 64'(o_ch), 64'(tq[i].ech));
        chk($sformatf("row%0d last", i), 64'(o_l), 64'(tq[i].el));
      end
      @(posedge clk_data); #1;
    end
    v = 1'b0; s = 1'b0;
  endtask

  initial begin
    int base, end_c, end_d, end_e, r0, rc;
    int br[8];
    logic [15:0] rnd[400];

    // ---- A: basic, sync on beat 0, beats 1..8 back to back
    base = tq.size();
    for (int k = 0; k < 8; k++) add(1'b1, k == 0, 16'(k + 1));
    add(1'b0, 1'b0, 16'd0); add(1'b0, 1'b0, 16'd0);
    for (int c = 0; c < 4; c++) expo(base + 6 + c, 32'(6 + 2 * c), 2'(c), c == 3);

    // ---- B: same data, 1..3 idle cycles after each beat
    for (int k = 0; k < 8; k++) begin
      br[k] = tq.size();
      add(1'b1, 1'b0, 16'(k + 1));
      for (int g = 0; g < (k % 3) + 1; g++) add(1'b0, 1'b0, 16'd0);
    end
    for (int k = 4; k < 8; k++) expo(br[k] + 2, 32'(6 + 2 * (k - 4)), 2'(k - 4), k == 7);

    // ---- C: sync on third beat restarts at chan 0, frame 0
    add(1'b1, 1'b0, 16'd10); add(1'b1, 1'b0, 16'd20);
    rc = tq.size();
    add(1'b1, 1'b1, 16'd30); add(1'b1, 1'b0, 16'd1);
    add(1'b1, 1'b0, 16'd2);  add(1'b1, 1'b0, 16'd3);
    r0 = tq.size();
    add(1'b1, 1'b0, 16'd100); add(1'b1, 1'b0, 16'd200);
    add(1'b1, 1'b0, 16'd300); add(1'b1, 1'b0, 16'd400);
    add(1'b0, 1'b0, 16'd0);   add(1'b0, 1'b0, 16'd0);
    exp_serr(rc + 1);
    expo(r0 + 2, 32'd130, 2'd0, 1'b0); expo(r0 + 3, 32'd201, 2'd1, 1'b0);
    expo(r0 + 4, 32'd302, 2'd2, 1'b0); expo(r0 + 5, 32'd403, 2'd3, 1'b1);
    end_c = tq.size();

    // ---- D: all-ones input, two spectra
    for (int k = 0; k < 8; k++) add(1'b1, k == 0, 16'hFFFF);
    add(1'b0, 1'b0, 16'd0); add(1'b0, 1'b0, 16'd0);
    for (int c = 0; c < 4; c++) expo(end_c + 6 + c, 32'h1FFFE, 2'(c), c == 3);
    end_d = tq.size();

    // ---- E: 100 random spectra; expected sums from a per-channel pair model
    for (int i = 0; i < 400; i++) begin
      rnd[i] = 16'($urandom_range(0, 65535));
      add(1'b1, (i % 4) == 0, rnd[i]);
    end
    add(1'b0, 1'b0, 16'd0); add(1'b0, 1'b0, 16'd0);
    for (int sp = 1; sp < 100; sp += 2)
      for (int c = 0; c < 4; c++)
        expo(end_d + sp * 4 + c + 2, 32'(rnd[(sp - 1) * 4 + c]) + 32'(rnd[sp * 4 + c]),
             2'(c), c == 3);
    end_e = tq.size();

    // ---- reset state
    rst = 1'b1;
    repeat (3) @(posedge clk_data);
    @(negedge clk_data);
    chk("rst data_out", 64'(o_d), 64'd0);
    chk("rst chan", 64'(o_ch), 64'd0);
    chk("rst valid", 64'(o_v), 64'd0);
    chk("rst last", 64'(o_l), 64'd0);
    chk("rst sync_err", 64'(o_se), 64'd0);
    chk("rst sat", 64'(o_sat), 64'd0);
    chk("rst sat16 sat", 64'(q_sat), 64'd0);
    @(posedge clk_data); #1;
    rst = 1'b0;

    run(0, end_c);
    chk("sat16 clear before D", 64'(q_sat), 64'd0);
    run(end_c, end_d);
    chk("sat16 data_out", 64'(q_d), 64'hFFFF);
    chk("sat16 sat_flag", 64'(q_sat), 64'd1);
    chk("acc32 no sat", 64'(o_sat), 64'd0);
    run(end_d, end_e);
    chk("sat16 sticky", 64'(q_sat), 64'd1);
    chk("acc32 no sat after random", 64'(o_sat), 64'd0);

    // ---- reset during frame 1, chan 2
    for (int c = 0; c < 4; c++) begin
      v = 1'b1; s = (c == 0); d = 16'd7;
      @(posedge clk_data); #1;
    end
    s = 1'b0; d = 16'd7;
    @(posedge clk_data); #1;          // frame 1 chan 0
    @(posedge clk_data); #1;          // frame 1 chan 1
    rst = 1'b1;                       // frame 1 chan 2 beat dropped
    @(negedge clk_data);
    chk("pre-rst out valid", 64'(o_v), 64'd1);
    chk("pre-rst out data", 64'(o_d), 64'd14);
    @(posedge clk_data); #1;
    v = 1'b0;
    @(negedge clk_data);
    chk("mid rst valid", 64'(o_v), 64'd0);
    chk("mid rst data", 64'(o_d), 64'd0);
    chk("mid rst sat16", 64'(q_sat), 64'd0);
    @(posedge clk_data); #1;
    rst = 1'b0;

    base = tq.size();
    for (int k = 0; k < 4; k++) add(1'b0, 1'b0, 16'd0);
    for (int k = 0; k < 8; k++) add(1'b1, 1'b0, 16'd5);
    add(1'b0, 1'b0, 16'd0); add(1'b0, 1'b0, 16'd0);
    for (int c = 0; c < 4; c++) expo(base + 4 + 6 + c, 32'd10, 2'(c), c == 3);
    run(base, tq.size());
    chk("final sat", 64'(o_sat), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
